// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// acc_pkg : opcodes, FSM encoding and multiplier step count for accumulator_unit
// Revision: 1.0
// ============================================================================
package acc_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_LDR  = 4'd2;
  localparam logic [3:0] OP_STR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int MUL_STEPS = 8;

endpackage
`default_nettype wire

// File: rtl/accumulator_unit_mul.sv
`default_nettype none
// ============================================================================
// shift_add_multiplier : unsigned W x W multiplier, one shift-add step per cycle
// Revision: 1.0
// ============================================================================
module shift_add_multiplier
  import acc_pkg::*;
#(
  parameter int W = MUL_STEPS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] product_o
);

  localparam int CW = $clog2(W);

  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] prod_q;
  logic [2*W-1:0] prod_d;
  logic [W-1:0]   mplier_q;

  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      mcand_q  <= {{W{1'b0}}, a_i};
      prod_q   <= '0;
      mplier_q <= b_i;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // The final partial sum is presented combinationally so the caller can
  // capture the full product on the same edge as the last step.
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(W - 1));
  assign product_o = prod_d;

endmodule
`default_nettype wire

// File: rtl/accumulator_unit.sv
`default_nettype none
// ============================================================================
// accumulator_unit : 8-bit accumulator stage with ALU, multi-cycle MUL,
// STR write-back and one-entry write-back forwarding.
// Revision: 1.0
// ============================================================================
module accumulator_unit
  import acc_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int INDEX_SIZE  = 4,
  parameter int OPCODE_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [INDEX_SIZE-1:0]  reg_index,
  input  logic [WORD_SIZE-1:0]   imm,
  output logic [INDEX_SIZE-1:0]  read_address,
  input  logic [WORD_SIZE-1:0]   operand,
  output logic                   write_enable,
  output logic [INDEX_SIZE-1:0]  write_address,
  output logic [WORD_SIZE-1:0]   write_data,
  output logic [WORD_SIZE-1:0]   acc,
  output logic                   zero,
  output logic                   carry
);

  state_e                  state_q;
  logic [WORD_SIZE-1:0]    acc_q;
  logic                    zero_q;
  logic                    carry_q;
  logic                    ready_q;
  logic                    we_q;
  logic [INDEX_SIZE-1:0]   waddr_q;
  logic [WORD_SIZE-1:0]    wdata_q;

  logic [WORD_SIZE-1:0]    src;
  logic [WORD_SIZE-1:0]    add_b;
  logic [WORD_SIZE:0]      sum;
  logic [WORD_SIZE:0]      diff;
  logic [WORD_SIZE-1:0]    acc_d;
  logic                    carry_d;
  logic                    acc_wr;
  logic                    accept;
  logic                    mul_start;
  logic                    mul_busy;
  logic                    mul_done;
  logic [2*WORD_SIZE-1:0]  mul_product;

  assign read_address = reg_index;
  assign accept       = op_valid && op_ready;
  assign mul_start    = accept && (opcode == OP_MUL);

  // A write pulse in flight has not reached the file yet, so bypass it.
  assign src   = (we_q && (waddr_q == reg_index)) ? wdata_q : operand;
  assign add_b = (opcode == OP_ADDI) ? imm : src;
  assign sum   = {1'b0, acc_q} + {1'b0, add_b};
  assign diff  = {1'b0, acc_q} - {1'b0, src};

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    acc_wr  = 1'b1;
    case (opcode)
      OP_LDI:          begin acc_d = imm;           carry_d = 1'b0; end
      OP_LDR:          begin acc_d = src;           carry_d = 1'b0; end
      OP_ADD, OP_ADDI: {carry_d, acc_d} = sum;
      OP_SUB:          {carry_d, acc_d} = diff;
      OP_AND:          begin acc_d = acc_q & src;   carry_d = 1'b0; end
      OP_OR:           begin acc_d = acc_q | src;   carry_d = 1'b0; end
      OP_XOR:          begin acc_d = acc_q ^ src;   carry_d = 1'b0; end
      OP_SHL:          {carry_d, acc_d} = {acc_q, 1'b0};
      OP_SHR:          {acc_d, carry_d} = {1'b0, acc_q};
      default:         acc_wr = 1'b0;
    endcase
  end

  shift_add_multiplier #(
    .W (WORD_SIZE)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (acc_q),
    .b_i       (src),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (opcode == OP_STR) begin
              we_q    <= 1'b1;
              waddr_q <= reg_index;
              wdata_q <= acc_q;
            end else if (opcode == OP_MUL) begin
              state_q <= ST_MUL;
              ready_q <= 1'b0;
            end else if (acc_wr) begin
              acc_q   <= acc_d;
              carry_q <= carry_d;
              zero_q  <= (acc_d == '0);
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            acc_q   <= mul_product[WORD_SIZE-1:0];
            carry_q <= |mul_product[2*WORD_SIZE-1:WORD_SIZE];
            zero_q  <= (mul_product[WORD_SIZE-1:0] == '0);
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign op_ready      = ready_q & ~mul_busy;
  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign acc           = acc_q;
  assign zero          = zero_q;
  assign carry         = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_unit.sv
`default_nettype none
// ============================================================================
// tb_accumulator_unit : directed and randomized checks of accumulator_unit
// against an arithmetic model with an attached 16x8 register file.
// Revision: 1.0
// ============================================================================
module tb_accumulator_unit;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] opcode;
  logic [3:0] reg_index;
  logic [7:0] imm;
  logic [3:0] read_address;
  logic [7:0] operand;
  logic       write_enable;
  logic [3:0] write_address;
  logic [7:0] write_data;
  logic [7:0] acc;
  logic       zero;
  logic       carry;

  logic [7:0] rf [16];
  logic       rf_init;

  int n_checks;
  int n_fail;
  bit cmp_en;
  int run_len;
  int last_run;

  int m_acc, m_zero, m_carry, m_busy, m_pacc, m_pcarry;
  int m_we, m_wa, m_wd;
  int m_rf [16];

  accumulator_unit #(
    .WORD_SIZE   (8),
    .INDEX_SIZE  (4),
    .OPCODE_SIZE (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .opcode        (opcode),
    .reg_index     (reg_index),
    .imm           (imm),
    .read_address  (read_address),
    .operand       (operand),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .acc           (acc),
    .zero          (zero),
    .carry         (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int init_val(input int i);
    if (i == 2) return 8'h5A;
    if (i == 3) return 44;
    if (i == 5) return 13;
    return (i * 37 + 11) % 256;
  endfunction

  // Register file: combinational read, write committed at the end of the pulse cycle
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'(init_val(i));
    end else if (write_enable) begin
      rf[write_address] <= write_data;
    end
  end
  assign operand = rf[read_address];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural model: register values are visible to later ops as soon as
  // the STR is accepted; MUL result appears eight cycles after acceptance.
  initial begin
    int src, s;
    for (int i = 0; i < 16; i++) m_rf[i] = init_val(i);
    m_acc = 0; m_zero = 1; m_carry = 0; m_busy = 0;
    m_pacc = 0; m_pcarry = 0; m_we = 0; m_wa = 0; m_wd = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_acc = 0; m_zero = 1; m_carry = 0; m_busy = 0;
        m_we = 0; m_wa = 0; m_wd = 0;
      end else begin
        m_we = 0;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            m_acc = m_pacc; m_carry = m_pcarry; m_zero = (m_pacc == 0);
          end
        end else if (op_valid) begin
          src = m_rf[reg_index];
          case (int'(opcode))
            1:  begin m_acc = imm; m_carry = 0; m_zero = (m_acc == 0); end
            2:  begin m_acc = src; m_carry = 0; m_zero = (m_acc == 0); end
            3:  begin m_we = 1; m_wa = reg_index; m_wd = m_acc; m_rf[reg_index] = m_acc; end
            4:  begin s = m_acc + src; m_acc = s % 256; m_carry = (s > 255); m_zero = (m_acc == 0); end
            5:  begin s = m_acc - src; m_carry = (s < 0); m_acc = (s + 256) % 256; m_zero = (m_acc == 0); end
            6:  begin m_acc = m_acc & src; m_carry = 0; m_zero = (m_acc == 0); end
            7:  begin m_acc = m_acc | src; m_carry = 0; m_zero = (m_acc == 0); end
            8:  begin m_acc = m_acc ^ src; m_carry = 0; m_zero = (m_acc == 0); end
            9:  begin s = m_acc + imm; m_acc = s % 256; m_carry = (s > 255); m_zero = (m_acc == 0); end
            10: begin m_carry = (m_acc >= 128); m_acc = (m_acc * 2) % 256; m_zero = (m_acc == 0); end
            11: begin m_carry = m_acc % 2; m_acc = m_acc / 2; m_zero = (m_acc == 0); end
            12: begin s = m_acc * src; m_pacc = s % 256; m_pcarry = (s > 255); m_busy = 8; end
            default: ;
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        chk("acc", int'(acc), m_acc);
        chk("zero", int'(zero), m_zero);
        chk("carry", int'(carry), m_carry);
        chk("op_ready", int'(op_ready), int'(m_busy == 0));
        chk("write_enable", int'(write_enable), m_we);
        if (m_we != 0) begin
          chk("write_address", int'(write_address), m_wa);
          chk("write_data", int'(write_data), m_wd);
        end
        chk("read_address", int'(read_address), int'(reg_index));
      end
    end
  end

  // Length of the most recent op_ready-low stretch
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) run_len = 0;
      else if (!op_ready) run_len++;
      else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Offer an op and hold it until accepted; returns 2 time units after the accepting edge
  task automatic issue(input int op, input int idx, input int im);
    bit rdy;
    rdy = 1'b0;
    op_valid  = 1'b1;
    opcode    = 4'(op);
    reg_index = 4'(idx);
    imm       = 8'(im);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rdy = op_ready;
      @(posedge clk);
      #2;
      if (rdy) break;
    end
    if (!rdy) chk("issue_timeout", 0, 1);
    op_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cmp_en = 1'b0;
    run_len = 0; last_run = 0;
    op_valid = 1'b0; opcode = 4'd0; reg_index = 4'd0; imm = 8'd0;
    rst_n = 1'b0; rf_init = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rf_init = 1'b0;
    rst_n   = 1'b1;
    cmp_en  = 1'b1;

    // Reset with a nonzero accumulator
    issue(1, 0, 55);
    chk("ldi55_acc", int'(acc), 55);
    rst_n = 1'b0;
    settle();
    chk("rst_async_acc", int'(acc), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc", int'(acc), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_carry", int'(carry), 0);
    chk("rst_ready", int'(op_ready), 1);
    chk("rst_we", int'(write_enable), 0);
    settle();

    // Add with carry out, then subtract to zero
    issue(1, 0, 200);
    issue(9, 0, 100);
    chk("addi_acc", int'(acc), 44);
    chk("addi_carry", int'(carry), 1);
    chk("addi_zero", int'(zero), 0);
    issue(5, 3, 0);
    chk("sub_acc", int'(acc), 0);
    chk("sub_zero", int'(zero), 1);
    chk("sub_carry", int'(carry), 0);

    // STR followed immediately by LDR of the same register
    issue(1, 0, 7);
    issue(3, 2, 0);
    issue(2, 2, 0);
    chk("fwd_ldr_acc", int'(acc), 7);
    chk("str_r2", int'(rf[2]), 7);

    // MUL 20*13 = 260, with an STR held while busy
    issue(1, 0, 20);
    issue(12, 5, 0);
    issue(3, 6, 0);
    chk("mul_acc", int'(acc), 4);
    chk("mul_carry", int'(carry), 1);
    chk("mul_zero", int'(zero), 0);
    chk("mul_busy_cycles", last_run, 8);
    settle();
    chk("held_str_r6", int'(rf[6]), 4);

    // Reset in the middle of a MUL
    issue(1, 0, 20);
    issue(12, 5, 0);
    repeat (4) settle();
    rst_n = 1'b0;
    settle();
    chk("midmul_async_acc", int'(acc), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midmul_acc", int'(acc), 0);
    chk("midmul_zero", int'(zero), 1);
    chk("midmul_carry", int'(carry), 0);
    chk("midmul_ready", int'(op_ready), 1);
    chk("midmul_we", int'(write_enable), 0);
    settle();
    repeat (8) settle();
    issue(1, 0, 9);
    chk("post_rst_ldi", int'(acc), 9);

    // Shifts and an unused opcode
    issue(1, 0, 8'h81);
    issue(10, 0, 0);
    chk("shl_acc", int'(acc), 2);
    chk("shl_carry", int'(carry), 1);
    issue(1, 0, 1);
    issue(11, 0, 0);
    chk("shr_acc", int'(acc), 0);
    chk("shr_zero", int'(zero), 1);
    chk("shr_carry", int'(carry), 1);
    issue(15, 0, 0);
    chk("op15_acc", int'(acc), 0);
    chk("op15_zero", int'(zero), 1);
    chk("op15_carry", int'(carry), 1);

    // Randomized traffic, small register range to exercise forwarding
    for (int k = 0; k < 400; k++) begin
      int gap;
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      gap = int'($urandom_range(0, 3));
      if (gap == 3) repeat (2) settle();
    end

    repeat (12) settle();
    for (int i = 0; i < 16; i++) chk("final_rf", int'(rf[i]), m_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
